// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the async FIFO write port: grants one requester at a time
// for a burst of up to MAX_BURST words, stalls on wfull and rotates priority after each burst.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  input  logic                      wfull,
  output logic [NREQ-1:0]           ack,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy
);

  // state | meaning
  // IDLE  | arbitration bubble; picks next owner round-robin from last_gnt+1
  // BURST | owner holds the write port; one word per cycle unless wfull

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic [CW-1:0]   count;
  logic            owner_req;
  logic            last_beat;

  // Scan downward in priority order so the highest-priority requester is written last.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_gnt) + k) % NREQ);
      if (req[cand]) pick = cand;
    end
  end

  assign owner_req = req[owner];
  assign last_beat = (count == CW'(MAX_BURST - 1));

  // A reset edge discards the beat, so the FIFO must not see a write on it either.
  assign winc = (state == BURST) & owner_req & ~wfull & ~rst;

  always_comb begin
    ack        = '0;
    ack[owner] = winc;
  end

  assign wdata  = (state == BURST) ? req_data[owner*DSIZE +: DSIZE] : '0;
  assign gnt_id = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      last_gnt <= IW'(NREQ - 1);
      count    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= pick;
            count <= '0;
            state <= BURST;
            busy  <= 1'b1;
          end
        end
        BURST: begin
          if (!owner_req || (winc && last_beat)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            last_gnt <= owner;
            count    <= '0;
          end else if (winc) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a transaction-level round-robin model.
module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic                    wfull;
  logic [NREQ-1:0]         ack;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    busy;

  fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .wfull(wfull),
    .ack(ack), .winc(winc), .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the port, who was served last, words moved in this burst.
  bit              m_known = 0;
  bit              m_busy;
  bit              m_fresh;
  int              m_owner;
  int              m_last;
  int              m_words;
  logic [DSIZE-1:0] lane [NREQ];
  logic [NREQ-1:0] last_ack;
  int              burst_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_known = 1;
    m_busy  = 0;
    m_fresh = 1;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_words = 0;
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic wf, input logic rs);
    logic            e_winc;
    logic [NREQ-1:0] e_ack;
    logic [DSIZE-1:0] e_wdata;
    req   = r;
    wfull = wf;
    rst   = rs;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = lane[i];
    @(negedge clk);
    e_winc  = m_busy && r[m_owner] && !wf && !rs;
    e_ack   = '0;
    if (e_winc) e_ack[m_owner] = 1'b1;
    e_wdata = m_busy ? lane[m_owner] : '0;
    last_ack = e_ack;
    if (m_known) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("winc", 32'(winc), 32'(e_winc));
      check("ack", 32'(ack), 32'(e_ack));
      check("wdata", 32'(wdata), 32'(e_wdata));
      if (m_busy || m_fresh) check("gnt_id", 32'(gnt_id), 32'(m_owner));
    end
    if (e_winc) lane[m_owner] = DSIZE'($urandom);
    if (rs) begin
      model_reset();
    end else if (m_known) begin
      if (!m_busy) begin
        if (r != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (r[(m_last + k) % NREQ]) begin
              m_owner = (m_last + k) % NREQ;
              break;
            end
          end
          m_busy  = 1;
          m_fresh = 0;
          m_words = 0;
          burst_cnt++;
        end
      end else if (!r[m_owner]) begin
        m_busy = 0;
        m_last = m_owner;
      end else if (e_winc) begin
        m_words++;
        if (m_words == MAX_BURST) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] want;

  initial begin
    for (int i = 0; i < NREQ; i++) lane[i] = DSIZE'($urandom);
    last_ack = '0;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    // lone requester 0: four beats, bubble, re-grant
    for (int c = 0; c < 8; c++) step(4'b0001, 1'b0, 1'b0);
    // all requesting: rotation 0,1,2,3,0
    for (int c = 0; c < 26; c++) step(4'b1111, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    // owner 2 stalled by wfull mid-burst
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b0100, 1'b0, 1'b0);
    // owner 1 abandons after two beats
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b0, 1'b0);
    // reset mid-burst, then 1010
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(4'b1010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    // requester 3 against a permanently full FIFO, then release
    for (int c = 0; c < 6; c++) step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    want = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_ack[i]) want[i] = ($urandom_range(1, 0) == 1);
        else if (!want[i]) want[i] = ($urandom_range(2, 0) == 0);
      end
      if (m_busy && $urandom_range(24, 0) == 0) want[m_owner] = 1'b0;
      step(want, ($urandom_range(3, 0) == 0), ($urandom_range(199, 0) == 0));
    end

    check("bursts_seen", 32'(burst_cnt > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
